// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract controller driving one full-adder cell, LSB first.
// Owns operand shifters, carry flop, bit counter and the IDLE/RUN/DONE FSM.
module serial_addsub_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ack,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_q;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             cout_q;
    logic             ovf_q;
    logic             s;
    logic             c;
    logic             last;

    // Full-adder cell on the current LSBs
    assign s    = a_sh[0] ^ b_sh[0] ^ carry;
    assign c    = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
    assign last = (cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last) state_nx = DONE;
            DONE:    if (res_ack) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_q  <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh   <= a;
                        // Subtract as A + ~B + 1
                        b_sh   <= op_sub ? ~b : b;
                        carry  <= op_sub;
                        cnt    <= '0;
                        res_q  <= '0;
                        cout_q <= 1'b0;
                        ovf_q  <= 1'b0;
                    end
                end
                RUN: begin
                    res_q <= {s, res_q[WIDTH-1:1]};
                    a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
                    carry <= c;
                    if (last) begin
                        ovf_q  <= carry ^ c;
                        cout_q <= c;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign res_valid = (state == DONE);
    assign result    = res_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Directed bench for serial_addsub_ctrl (WIDTH=4) with
// hand-computed expected results and immediate assertions.
module tb_serial_addsub_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       op_sub;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       res_valid;
    logic       res_ack;
    logic [3:0] result;
    logic       cout;
    logic       overflow;

    int vectors;
    int miscompares;
    int n;

    serial_addsub_ctrl #(.WIDTH(4), .CNT_W(3)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .op_sub(op_sub),
        .a(a),
        .b(b),
        .busy(busy),
        .res_valid(res_valid),
        .res_ack(res_ack),
        .result(result),
        .cout(cout),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents a request for exactly one rising edge (E0)
    task automatic start_op(input logic [3:0] ta, input logic [3:0] tb,
                            input logic ts);
        @(negedge clk);
        a      = ta;
        b      = tb;
        op_sub = ts;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    // Counts rising edges, E0 included, until res_valid appears
    task automatic wait_done(output int edges);
        edges = 1;
        while (!res_valid && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
        end
        if (!res_valid) chk("timeout", 32'(res_valid), 32'd1);
    endtask

    task automatic check_res(input string tag, input logic [3:0] r,
                             input logic co, input logic ov);
        chk({tag, ".result"}, 32'(result), 32'(r));
        chk({tag, ".cout"}, 32'(cout), 32'(co));
        chk({tag, ".ovf"}, 32'(overflow), 32'(ov));
    endtask

    task automatic ack_result(input string tag);
        @(negedge clk);
        res_ack = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, ".ack_busy"}, 32'(busy), 32'd0);
        chk({tag, ".ack_valid"}, 32'(res_valid), 32'd0);
        @(negedge clk);
        res_ack = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        op_sub  = 1'b0;
        a       = '0;
        b       = '0;
        res_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.valid", 32'(res_valid), 32'd0);
        check_res("rst", 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // 3+5: signed overflow into the MSB
        start_op(4'd3, 4'd5, 1'b0);
        chk("add35.busy", 32'(busy), 32'd1);
        wait_done(n);
        chk("add35.latency", 32'(n), 32'd5);
        check_res("add35", 4'd8, 1'b0, 1'b1);
        ack_result("add35");

        // 15+1 wraps; result held while unacknowledged
        start_op(4'd15, 4'd1, 1'b0);
        wait_done(n);
        chk("add151.latency", 32'(n), 32'd5);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check_res("add151.hold", 4'd0, 1'b1, 1'b0);
            chk("add151.busy", 32'(busy), 32'd1);
            chk("add151.valid", 32'(res_valid), 32'd1);
        end
        ack_result("add151");

        start_op(4'd5, 4'd3, 1'b1);
        wait_done(n);
        check_res("sub53", 4'd2, 1'b1, 1'b0);
        ack_result("sub53");

        start_op(4'd3, 4'd5, 1'b1);
        wait_done(n);
        check_res("sub35", 4'd14, 1'b0, 1'b0);
        ack_result("sub35");

        // -8-1 signed overflows
        start_op(4'd8, 4'd1, 1'b1);
        wait_done(n);
        check_res("sub81", 4'd7, 1'b1, 1'b1);

        // ack and start together in DONE: start must not be taken
        @(negedge clk);
        res_ack = 1'b1;
        start   = 1'b1;
        a       = 4'd1;
        b       = 4'd1;
        op_sub  = 1'b0;
        @(posedge clk);
        #1;
        chk("b2b.idle_busy", 32'(busy), 32'd0);
        chk("b2b.idle_valid", 32'(res_valid), 32'd0);
        @(negedge clk);
        res_ack = 1'b0;
        @(posedge clk);
        #1;
        chk("b2b.accept", 32'(busy), 32'd1);
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        chk("b2b.latency", 32'(n), 32'd5);
        check_res("b2b", 4'd2, 1'b0, 1'b0);
        ack_result("b2b");

        // Requests and operand changes during RUN are ignored
        start_op(4'd2, 4'd3, 1'b0);
        @(negedge clk);
        a      = 4'd9;
        b      = 4'd9;
        op_sub = 1'b1;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        a      = 4'd15;
        b      = 4'd7;
        wait_done(n);
        check_res("ign", 4'd5, 1'b0, 1'b0);
        ack_result("ign");
        @(posedge clk);
        #1;
        chk("ign.stay_idle", 32'(busy), 32'd0);

        // Asynchronous reset after two bits abandons the operation
        start_op(4'd7, 4'd7, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst.busy", 32'(busy), 32'd0);
        chk("arst.valid", 32'(res_valid), 32'd0);
        chk("arst.result", 32'(result), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        start_op(4'd6, 4'd6, 1'b0);
        wait_done(n);
        chk("add66.latency", 32'(n), 32'd5);
        check_res("add66", 4'd12, 1'b0, 1'b1);
        ack_result("add66");

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
